// File: rtl/mux_n_scan.sv
`default_nettype none
// ============================================================================
// Module  : mux_n_scan
// Brief   : N-channel, W-bit registered multiplexer with a manual select mode
//           and an automatic scan mode that dwells DWELL cycles per channel.
// Revision: 1.0 - initial release
// ============================================================================
module mux_n_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] X,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          Y,
  output logic                      y_valid,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      wrap,
  output logic                      sel_err
);

  // One bit minimum so DWELL=1 still has a legal counter.
  localparam int c_cnt_w    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int c_last_ch  = CHANNELS - 1;
  localparam int c_last_cnt = DWELL - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t             r_state, w_state_nx;
  logic [WIDTH-1:0]   r_y, w_y_nx;
  logic               r_valid, w_valid_nx;
  logic [SEL_W-1:0]   r_cur, w_cur_nx;
  logic               r_wrap, w_wrap_nx;
  logic               r_err, w_err_nx;
  logic [c_cnt_w-1:0] r_dwell_cnt, w_dwell_cnt_nx;

  logic [WIDTH-1:0]   w_chan [CHANNELS];
  logic [WIDTH-1:0]   w_man_data;
  logic [WIDTH-1:0]   w_scan_data;
  logic               w_sel_oor;
  logic               w_do_entry;
  logic               w_do_manual;
  logic               w_do_step;

  // Split the packed input bus into individual channels.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign w_chan[gi] = X[gi*WIDTH +: WIDTH];
  end

  // Channel pickers; a select that names no channel yields zero.
  always_comb begin
    w_man_data  = '0;
    w_scan_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(sel) == i)   w_man_data  = w_chan[i];
      if (int'(r_cur) == i) w_scan_data = w_chan[i];
    end
  end

  assign w_sel_oor = (int'(sel) >= CHANNELS);

  // Next-state and next-output logic; en=0 freezes everything except the pulses.
  always_comb begin
    w_state_nx     = r_state;
    w_y_nx         = r_y;
    w_valid_nx     = 1'b0;
    w_cur_nx       = r_cur;
    w_wrap_nx      = 1'b0;
    w_err_nx       = r_err;
    w_dwell_cnt_nx = r_dwell_cnt;
    w_do_entry     = 1'b0;
    w_do_manual    = 1'b0;
    w_do_step      = 1'b0;

    if (en) begin
      case (r_state)
        ST_IDLE, ST_MANUAL: begin
          if (mode) w_do_entry  = 1'b1;
          else      w_do_manual = 1'b1;
        end
        ST_SCAN: begin
          if (mode) w_do_step   = 1'b1;
          else      w_do_manual = 1'b1;
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end

    if (w_do_entry) begin
      // Scan always restarts from channel 0; Y keeps its old value for one cycle.
      w_state_nx     = ST_SCAN;
      w_cur_nx       = '0;
      w_dwell_cnt_nx = '0;
      w_err_nx       = 1'b0;
    end

    if (w_do_manual) begin
      w_state_nx = ST_MANUAL;
      w_cur_nx   = sel;
      w_valid_nx = 1'b1;
      w_err_nx   = w_sel_oor;
      w_y_nx     = w_sel_oor ? '0 : w_man_data;
    end

    if (w_do_step) begin
      w_y_nx     = w_scan_data;
      w_valid_nx = 1'b1;
      w_err_nx   = 1'b0;
      if (int'(r_dwell_cnt) == c_last_cnt) begin
        w_dwell_cnt_nx = '0;
        if (int'(r_cur) == c_last_ch) begin
          w_cur_nx  = '0;
          w_wrap_nx = 1'b1;
        end else begin
          w_cur_nx  = r_cur + 1'b1;
        end
      end else begin
        w_dwell_cnt_nx = r_dwell_cnt + 1'b1;
      end
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_y         <= '0;
      r_valid     <= 1'b0;
      r_cur       <= '0;
      r_wrap      <= 1'b0;
      r_err       <= 1'b0;
      r_dwell_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_y         <= w_y_nx;
      r_valid     <= w_valid_nx;
      r_cur       <= w_cur_nx;
      r_wrap      <= w_wrap_nx;
      r_err       <= w_err_nx;
      r_dwell_cnt <= w_dwell_cnt_nx;
    end
  end

  assign Y       = r_y;
  assign y_valid = r_valid;
  assign cur_sel = r_cur;
  assign wrap    = r_wrap;
  assign sel_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_n_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_n_scan
// Brief   : Self-checking bench for mux_n_scan: a 4-channel DWELL=2 instance
//           and a 3-channel DWELL=1 instance sharing the same stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux_n_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] X   = 16'hDCBA;
  logic [1:0]  sel = 2'd0;
  logic        mode = 1'b0;
  logic        en   = 1'b0;

  logic [3:0]  y_a, y_b;
  logic        v_a, v_b, w_a, w_b, e_a, e_b;
  logic [1:0]  c_a, c_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_n_scan #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(2)) dut (
    .clk(clk), .rst(rst), .X(X), .sel(sel), .mode(mode), .en(en),
    .Y(y_a), .y_valid(v_a), .cur_sel(c_a), .wrap(w_a), .sel_err(e_a));

  mux_n_scan #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(1)) dut3 (
    .clk(clk), .rst(rst), .X(X[11:0]), .sel(sel), .mode(mode), .en(en),
    .Y(y_b), .y_valid(v_b), .cur_sel(c_b), .wrap(w_b), .sel_err(e_b));

  // Reference model: scan position is a plain step count n since scan entry.
  typedef struct {
    int         st;    // 0 idle, 1 manual, 2 scan
    int         n;
    logic [3:0] y;
    logic       yv;
    int         cur;
    logic       wrap;
    logic       err;
  } model_t;

  model_t m [2];
  int     mch [2] = '{4, 3};
  int     mdw [2] = '{2, 1};

  function automatic logic [3:0] chan_of(input logic [15:0] x, input int c);
    logic [15:0] t;
    t = x >> (4 * c);
    return t[3:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].st = 0; m[i].n = 0; m[i].y = 4'h0; m[i].yv = 1'b0;
      m[i].cur = 0; m[i].wrap = 1'b0; m[i].err = 1'b0;
    end
  endtask

  task automatic model_edge(input int i);
    if (!en) begin
      m[i].yv = 1'b0; m[i].wrap = 1'b0;
    end else if (mode && m[i].st != 2) begin
      m[i].st = 2; m[i].n = 0; m[i].cur = 0;
      m[i].yv = 1'b0; m[i].err = 1'b0; m[i].wrap = 1'b0;
    end else if (!mode) begin
      m[i].st = 1;
      m[i].err = (int'(sel) >= mch[i]);
      m[i].y = m[i].err ? 4'h0 : chan_of(X, int'(sel));
      m[i].cur = int'(sel);
      m[i].yv = 1'b1; m[i].wrap = 1'b0;
    end else begin
      m[i].y = chan_of(X, (m[i].n / mdw[i]) % mch[i]);
      m[i].yv = 1'b1; m[i].err = 1'b0;
      m[i].n = m[i].n + 1;
      m[i].cur = (m[i].n / mdw[i]) % mch[i];
      m[i].wrap = ((m[i].n % (mdw[i] * mch[i])) == 0);
    end
  endtask

  // Packed compare vector: {Y, y_valid, cur_sel, wrap, sel_err}.
  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got Y=%h v=%b cur=%0d wrap=%b err=%b, expected Y=%h v=%b cur=%0d wrap=%b err=%b",
               name, act[8:5], act[4], act[3:2], act[1], act[0],
               exp[8:5], exp[4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [8:0] mvec(input int i);
    logic [31:0] c;
    c = m[i].cur;
    return {m[i].y, m[i].yv, c[1:0], m[i].wrap, m[i].err};
  endfunction

  // One clock edge: advance the model, then sample outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  typedef struct {
    logic       mode;
    logic       en;
    logic [1:0] sel;
    logic [3:0] y;
    logic       yv;
    logic [1:0] cur;
    logic       wrap;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic md, input logic e, input logic [1:0] s,
                     input logic [3:0] y, input logic v, input logic [1:0] c, input logic w);
    vec_t r;
    r.mode = md; r.en = e; r.sel = s; r.y = y; r.yv = v; r.cur = c; r.wrap = w;
    tbl.push_back(r);
  endtask

  initial begin
    // Manual sweep
    add(0,1,0, 4'hA,1,0,0); add(0,1,1, 4'hB,1,1,0);
    add(0,1,2, 4'hC,1,2,0); add(0,1,3, 4'hD,1,3,0);
    // Scan entry, first channel, first B
    add(1,1,0, 4'hD,0,0,0); add(1,1,0, 4'hA,1,0,0);
    add(1,1,0, 4'hA,1,1,0); add(1,1,0, 4'hB,1,1,0);
    // Pause three cycles (middle one also requests a mode change)
    add(1,0,0, 4'hB,0,1,0); add(0,0,0, 4'hB,0,1,0); add(1,0,0, 4'hB,0,1,0);
    // Resume: one more B, then C
    add(1,1,0, 4'hB,1,2,0); add(1,1,0, 4'hC,1,2,0);
    // Mode switch at first dwell cycle of C
    add(0,1,3, 4'hD,1,3,0);
    // Full scan lap with wrap on the D->A edge
    add(1,1,0, 4'hD,0,0,0);
    add(1,1,0, 4'hA,1,0,0); add(1,1,0, 4'hA,1,1,0);
    add(1,1,0, 4'hB,1,1,0); add(1,1,0, 4'hB,1,2,0);
    add(1,1,0, 4'hC,1,2,0); add(1,1,0, 4'hC,1,3,0);
    add(1,1,0, 4'hD,1,3,0); add(1,1,0, 4'hD,1,0,1);
    add(1,1,0, 4'hA,1,0,0); add(1,1,0, 4'hA,1,1,0);

    // Initial asynchronous reset
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("reset_a", {y_a, v_a, c_a, w_a, e_a}, 9'h0);
    check("reset_b", {y_b, v_b, c_b, w_b, e_b}, 9'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;

    // Table-driven directed vectors
    foreach (tbl[k]) begin
      mode = tbl[k].mode; en = tbl[k].en; sel = tbl[k].sel;
      step();
      check($sformatf("tbl%0d_a", k), {y_a, v_a, c_a, w_a, e_a},
            {tbl[k].y, tbl[k].yv, tbl[k].cur, tbl[k].wrap, 1'b0});
      check($sformatf("tbl%0d_b", k), {y_b, v_b, c_b, w_b, e_b}, mvec(1));
    end

    // Out-of-range select on the 3-channel instance
    mode = 0; en = 1; sel = 2'd3;
    step();
    check("oor_b", {y_b, v_b, c_b, w_b, e_b}, {4'h0, 1'b1, 2'd3, 1'b0, 1'b1});
    check("oor_a", {y_a, v_a, c_a, w_a, e_a}, {4'hD, 1'b1, 2'd3, 1'b0, 1'b0});
    sel = 2'd1;
    step();
    check("inrange_b", {y_b, v_b, c_b, w_b, e_b}, {4'hB, 1'b1, 2'd1, 1'b0, 1'b0});

    // Asynchronous reset mid-scan, observed before any clock edge
    mode = 1;
    step(); step(); step(); step();
    rst = 1'b1;
    #1;
    check("midscan_rst_a", {y_a, v_a, c_a, w_a, e_a}, 9'h0);
    check("midscan_rst_b", {y_b, v_b, c_b, w_b, e_b}, 9'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized run against the model
    for (int r = 0; r < 400; r++) begin
      @(negedge clk);
      X = 16'($urandom);
      sel = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      step();
      check($sformatf("rnd%0d_a", r), {y_a, v_a, c_a, w_a, e_a}, mvec(0));
      check($sformatf("rnd%0d_b", r), {y_b, v_b, c_b, w_b, e_b}, mvec(1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
